// File: rtl/ysyx_23060191_gpr.sv
// General-purpose register file with write-back acceptance, two
// combinational read ports with same-cycle write bypass, and a per-register
// pending-write scoreboard used by decode for RAW hazard detection.
module ysyx_23060191_gpr #(
    parameter int CPU_WIDTH = 32,
    parameter int REG_NUM   = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [ADDR_W-1:0]    wb_rd,
    input  logic [CPU_WIDTH-1:0] wb_data,
    input  logic [ADDR_W-1:0]    rs1_addr,
    input  logic [ADDR_W-1:0]    rs2_addr,
    output logic [CPU_WIDTH-1:0] rs1_data,
    output logic [CPU_WIDTH-1:0] rs2_data,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    input  logic                 iss_valid,
    input  logic [ADDR_W-1:0]    iss_rd,
    output logic                 iss_full,
    output logic                 err
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};

    // Architectural state
    logic [CPU_WIDTH-1:0] regs_r [REG_NUM];
    logic [1:0]           cnt_r  [REG_NUM];
    logic [1:0]           cnt_nxt_s [REG_NUM];
    logic                 wb_ready_r;
    logic                 err_r;

    // Decoded events
    logic wb_fire_s;
    logic wb_evt_s;
    logic iss_evt_s;
    logic iss_full_s;
    logic err_set_s;

    assign wb_fire_s = wb_valid & wb_ready_r;
    assign wb_evt_s  = wb_fire_s & (wb_rd != ZERO_IDX);

    // Saturation check for the issue port; x0 never counts as full
    always_comb begin
        iss_full_s = 1'b0;
        if (iss_rd != ZERO_IDX) begin
            iss_full_s = (cnt_r[iss_rd] == 2'd3);
        end else begin
            iss_full_s = 1'b0;
        end
    end

    assign iss_evt_s = iss_valid & (iss_rd != ZERO_IDX) & ~iss_full_s;

    // Protocol errors: issue into a saturated counter, or retire a write nobody issued
    always_comb begin
        err_set_s = 1'b0;
        if (iss_valid && iss_full_s) begin
            err_set_s = 1'b1;
        end else if (wb_evt_s && (cnt_r[wb_rd] == 2'd0)) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = 1'b0;
        end
    end

    // Next value of every pending counter; simultaneous issue and retire cancel out
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (i == 0) begin
                cnt_nxt_s[i] = 2'd0;
            end else begin
                case ({iss_evt_s && (iss_rd == ADDR_W'(i)),
                       wb_evt_s  && (wb_rd  == ADDR_W'(i))})
                    2'b10: cnt_nxt_s[i] = cnt_r[i] + 2'd1;
                    2'b01: begin
                        if (cnt_r[i] != 2'd0) begin
                            cnt_nxt_s[i] = cnt_r[i] - 2'd1;
                        end else begin
                            cnt_nxt_s[i] = 2'd0;
                        end
                    end
                    default: cnt_nxt_s[i] = cnt_r[i];
                endcase
            end
        end
    end

    // wb_ready rises on the first edge out of reset and stays high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ready_r <= 1'b0;
        end else begin
            wb_ready_r <= 1'b1;
        end
    end

    // Commit accepted write-backs; writes to x0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_r[i] <= {CPU_WIDTH{1'b0}};
            end
        end else if (wb_evt_s) begin
            regs_r[wb_rd] <= wb_data;
        end
    end

    // Pending-write scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                cnt_r[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end
    end

    // Read port 1: x0, then bypass of the firing write, then storage
    always_comb begin
        rs1_data = {CPU_WIDTH{1'b0}};
        if (rs1_addr == ZERO_IDX) begin
            rs1_data = {CPU_WIDTH{1'b0}};
        end else if (wb_fire_s && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs_r[rs1_addr];
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        rs2_data = {CPU_WIDTH{1'b0}};
        if (rs2_addr == ZERO_IDX) begin
            rs2_data = {CPU_WIDTH{1'b0}};
        end else if (wb_fire_s && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs_r[rs2_addr];
        end
    end

    // Busy on port 1, cleared when this cycle's write retires the last pending one
    always_comb begin
        rs1_busy = 1'b0;
        if (rs1_addr == ZERO_IDX) begin
            rs1_busy = 1'b0;
        end else if (wb_fire_s && (wb_rd == rs1_addr) && (cnt_r[rs1_addr] == 2'd1)) begin
            rs1_busy = 1'b0;
        end else begin
            rs1_busy = (cnt_r[rs1_addr] != 2'd0);
        end
    end

    // Busy on port 2, same rule as port 1
    always_comb begin
        rs2_busy = 1'b0;
        if (rs2_addr == ZERO_IDX) begin
            rs2_busy = 1'b0;
        end else if (wb_fire_s && (wb_rd == rs2_addr) && (cnt_r[rs2_addr] == 2'd1)) begin
            rs2_busy = 1'b0;
        end else begin
            rs2_busy = (cnt_r[rs2_addr] != 2'd0);
        end
    end

    assign wb_ready = wb_ready_r;
    assign iss_full = iss_full_s;
    assign err      = err_r;

endmodule

// File: tb/tb_ysyx_23060191_gpr.sv
// Directed self-checking bench for the register file and its scoreboard.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ysyx_23060191_gpr;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_full;
    logic        err;

    int n_checks;
    int n_errors;

    ysyx_23060191_gpr #(.CPU_WIDTH(32), .REG_NUM(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_full(iss_full),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge (one rising edge has passed in between)
    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; iss_valid = 1'b0; iss_rd = 5'd0;

        // Held in reset
        next_cyc(); settle();
        chk("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // Reset release
        rst_n = 1'b1;
        next_cyc();
        rs1_addr = 5'd5; settle();
        chk("rel_wb_ready", {31'd0, wb_ready}, 32'd1);
        chk("rel_x5_data", rs1_data, 32'd0);
        chk("rel_x5_busy", {31'd0, rs1_busy}, 32'd0);
        chk("rel_err", {31'd0, err}, 32'd0);

        // Issue x5, then write it back a cycle later
        iss_valid = 1'b1; iss_rd = 5'd5; settle();
        chk("x5_iss_full", {31'd0, iss_full}, 32'd0);
        next_cyc();
        iss_valid = 1'b0; iss_rd = 5'd0; settle();
        chk("x5_busy_after_iss", {31'd0, rs1_busy}, 32'd1);
        next_cyc();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; settle();
        chk("x5_bypass_data", rs1_data, 32'hDEADBEEF);
        chk("x5_bypass_busy", {31'd0, rs1_busy}, 32'd0);
        next_cyc();
        wb_valid = 1'b0; wb_data = 32'd0; settle();
        chk("x5_stored_data", rs1_data, 32'hDEADBEEF);
        chk("x5_stored_busy", {31'd0, rs1_busy}, 32'd0);

        // Write to x0 is discarded and not counted
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678; settle();
        chk("x0_rs1_same", rs1_data, 32'd0);
        chk("x0_rs2_same", rs2_data, 32'd0);
        next_cyc();
        wb_valid = 1'b0; settle();
        chk("x0_rs1_after", rs1_data, 32'd0);
        chk("x0_rs2_after", rs2_data, 32'd0);
        chk("x0_err", {31'd0, err}, 32'd0);

        // Saturate x7, drop a fourth issue, then drain
        rs2_addr = 5'd7;
        iss_valid = 1'b1; iss_rd = 5'd7;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("x7_full_before_iss%0d", k), {31'd0, iss_full}, 32'd0);
            next_cyc();
        end
        settle();
        chk("x7_full_at3", {31'd0, iss_full}, 32'd1);
        chk("x7_err_before_drop", {31'd0, err}, 32'd0);
        next_cyc();
        iss_valid = 1'b0; settle();
        chk("x7_err_after_drop", {31'd0, err}, 32'd1);
        chk("x7_full_after_drop", {31'd0, iss_full}, 32'd1);
        chk("x7_busy", {31'd0, rs2_busy}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h70 + 32'(k); settle();
            chk($sformatf("x7_busy_wb%0d", k), {31'd0, rs2_busy}, (k == 2) ? 32'd0 : 32'd1);
            next_cyc();
        end
        wb_valid = 1'b0; settle();
        chk("x7_busy_drained", {31'd0, rs2_busy}, 32'd0);
        chk("x7_full_drained", {31'd0, iss_full}, 32'd0);
        chk("x7_data", rs2_data, 32'h72);

        // Same-cycle issue and write-back of x9 with one pending write
        rs1_addr = 5'd9;
        iss_valid = 1'b1; iss_rd = 5'd9;
        next_cyc();
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0099; settle();
        chk("x9_same_busy", {31'd0, rs1_busy}, 32'd0);
        chk("x9_same_data", rs1_data, 32'h99);
        next_cyc();
        iss_valid = 1'b0; wb_valid = 1'b0; settle();
        chk("x9_busy_after", {31'd0, rs1_busy}, 32'd1);
        chk("x9_data_after", rs1_data, 32'h99);

        // Reset pulse clears everything asynchronously
        rst_n = 1'b0; settle();
        chk("rst2_wb_ready", {31'd0, wb_ready}, 32'd0);
        chk("rst2_err", {31'd0, err}, 32'd0);
        chk("rst2_x9_data", rs1_data, 32'd0);
        chk("rst2_x9_busy", {31'd0, rs1_busy}, 32'd0);
        rs2_addr = 5'd5; settle();
        chk("rst2_x5_data", rs2_data, 32'd0);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();

        // Write-back x3 with nothing pending
        rs1_addr = 5'd3; settle();
        chk("x3_err_before", {31'd0, err}, 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0033;
        next_cyc();
        wb_valid = 1'b0; settle();
        chk("x3_data", rs1_data, 32'h33);
        chk("x3_busy", {31'd0, rs1_busy}, 32'd0);
        chk("x3_err", {31'd0, err}, 32'd1);

        // Mid-run reset with a write-back in flight: the write is lost
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h0000_0044; rs2_addr = 5'd4;
        #2;
        rst_n = 1'b0; settle();
        chk("mid_x3_data", rs1_data, 32'd0);
        chk("mid_err", {31'd0, err}, 32'd0);
        chk("mid_wb_ready", {31'd0, wb_ready}, 32'd0);
        next_cyc();
        wb_valid = 1'b0; settle();
        chk("mid_x4_lost", rs2_data, 32'd0);
        rst_n = 1'b1;
        next_cyc(); settle();
        chk("mid_x4_after_release", rs2_data, 32'd0);
        chk("mid_wb_ready_back", {31'd0, wb_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
